// File: rtl/om_pkg.sv
// Shared definitions for the object-memory write path: geometry of the OM,
// watchdog limit, arbiter states and write-source selects.
package om_pkg;

    localparam int OM_DEPTH = 104;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 11;
    localparam int TIMEOUT  = 255;
    localparam int CNT_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        GRANT   = 2'd2,
        PLAYING = 2'd3
    } om_state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_GL   = 2'd1,
        SEL_NC   = 2'd2
    } om_sel_e;

endpackage

// File: rtl/om_write_mux.sv
// Registered 2:1 write mux in front of the OM RAM. The source is chosen by
// the arbiter; writes landing outside the populated OM range are dropped.
module om_write_mux
    import om_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  om_sel_e           sel,
    input  logic [ADDR_W-1:0] gl_addr,
    input  logic [DATA_W-1:0] gl_data,
    input  logic              gl_wren,
    input  logic [ADDR_W-1:0] nc_addr,
    input  logic [DATA_W-1:0] nc_data,
    input  logic              nc_wren,
    output logic [ADDR_W-1:0] om_addr,
    output logic [DATA_W-1:0] om_data,
    output logic              om_wren
);

    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] data_p0;
    logic              vld_p0;

    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;

    // Only entries below OM_DEPTH exist in the RAM.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(OM_DEPTH);
    endfunction

    // Stage p0: pick the owning writer; an unselected port drives zeros.
    always_comb begin
        addr_p0 = '0;
        data_p0 = '0;
        vld_p0  = 1'b0;
        case (sel)
            SEL_GL: begin
                addr_p0 = gl_addr;
                data_p0 = gl_data;
                vld_p0  = gl_wren;
            end
            SEL_NC: begin
                addr_p0 = nc_addr;
                data_p0 = nc_data;
                vld_p0  = nc_wren;
            end
            default: begin
                addr_p0 = '0;
                data_p0 = '0;
                vld_p0  = 1'b0;
            end
        endcase
    end

    // Stage p1: register the merged write, gating enables outside the OM.
    // Address/data are cleared on reset too so the RAM port reads all-zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_p1 <= '0;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            addr_p1 <= addr_p0;
            data_p1 <= data_p0;
            vld_p1  <= vld_p0 && addr_in_range(addr_p0);
        end
    end

    assign om_addr = addr_p1;
    assign om_data = data_p1;
    assign om_wren = vld_p1;

endmodule

// File: rtl/om_write_arbiter.sv
// Owner of the single OM write port. Hands the port to the new-game
// coordinator once game logic has finished its current move, returns it on
// new_game_ready, and aborts a load that stalls for TIMEOUT cycles.
module om_write_arbiter
    import om_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              new_game_request,
    input  logic              resetting,
    input  logic              new_game_ready,
    input  logic [ADDR_W-1:0] nc_addr,
    input  logic [DATA_W-1:0] nc_data,
    input  logic              nc_wren,
    input  logic [ADDR_W-1:0] gl_addr,
    input  logic [DATA_W-1:0] gl_data,
    input  logic              gl_wren,
    input  logic              gl_busy,
    output logic              new_game_in_progress,
    output logic              gl_hold,
    output logic              game_active,
    output logic              load_error,
    output logic [ADDR_W-1:0] om_addr,
    output logic [DATA_W-1:0] om_data,
    output logic              om_wren
);

    om_state_e         state;
    logic [CNT_W-1:0]  grant_cnt;
    om_sel_e           sel;

    // The coordinator's streaming flag carries no arbitration meaning here:
    // its writes are qualified by nc_wren alone.
    logic unused_resetting;
    assign unused_resetting = resetting;

    // Arbiter FSM with watchdog; all status outputs are registered here.
    // grant_cnt counts GRANT cycles already spent, so the abort fires on the
    // TIMEOUT-th GRANT cycle unless new_game_ready arrives in that same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            grant_cnt            <= '0;
            new_game_in_progress <= 1'b0;
            gl_hold              <= 1'b0;
            game_active          <= 1'b0;
            load_error           <= 1'b0;
        end else begin
            case (state)
                IDLE, PLAYING: begin
                    if (new_game_request) begin
                        state       <= DRAIN;
                        gl_hold     <= 1'b1;
                        game_active <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!gl_busy) begin
                        state                <= GRANT;
                        new_game_in_progress <= 1'b1;
                        load_error           <= 1'b0;
                        grant_cnt            <= '0;
                    end
                end
                GRANT: begin
                    if (new_game_ready) begin
                        state                <= PLAYING;
                        game_active          <= 1'b1;
                        gl_hold              <= 1'b0;
                        new_game_in_progress <= 1'b0;
                        grant_cnt            <= '0;
                    end else if (grant_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state                <= IDLE;
                        load_error           <= 1'b1;
                        gl_hold              <= 1'b0;
                        new_game_in_progress <= 1'b0;
                        grant_cnt            <= '0;
                    end else begin
                        grant_cnt <= grant_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Port ownership follows the current state; DRAIN keeps game logic on
    // the port so a move already in flight can finish its writes.
    always_comb begin
        sel = SEL_GL;
        case (state)
            IDLE:    sel = SEL_NONE;
            GRANT:   sel = SEL_NC;
            default: sel = SEL_GL;
        endcase
    end

    om_write_mux u_mux (
        .clk     (clk),
        .reset   (reset),
        .sel     (sel),
        .gl_addr (gl_addr),
        .gl_data (gl_data),
        .gl_wren (gl_wren),
        .nc_addr (nc_addr),
        .nc_data (nc_data),
        .nc_wren (nc_wren),
        .om_addr (om_addr),
        .om_data (om_data),
        .om_wren (om_wren)
    );

endmodule

// File: tb/tb_om_write_arbiter.sv
// Bench for om_write_arbiter: directed scenarios plus a random phase, all
// compared cycle by cycle against a flag-based behavioural model.
module tb_om_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_game_request = 1'b0;
    logic        resetting = 1'b0;
    logic        new_game_ready = 1'b0;
    logic [6:0]  nc_addr = '0;
    logic [10:0] nc_data = '0;
    logic        nc_wren = 1'b0;
    logic [6:0]  gl_addr = '0;
    logic [10:0] gl_data = '0;
    logic        gl_wren = 1'b0;
    logic        gl_busy = 1'b0;
    logic        new_game_in_progress;
    logic        gl_hold;
    logic        game_active;
    logic        load_error;
    logic [6:0]  om_addr;
    logic [10:0] om_data;
    logic        om_wren;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: what the board/ownership situation is, not how it is encoded.
    bit          m_loaded  = 0;   // a board was loaded successfully
    bit          m_waiting = 0;   // new game requested, game logic finishing
    bit          m_granted = 0;   // coordinator owns the port
    bit          m_err     = 0;
    int          m_age     = 0;   // GRANT cycles already elapsed
    logic [6:0]  m_addr    = '0;
    logic [10:0] m_data    = '0;
    bit          m_wren    = 0;

    om_write_arbiter dut (
        .clk                  (clk),
        .reset                (reset),
        .new_game_request     (new_game_request),
        .resetting            (resetting),
        .new_game_ready       (new_game_ready),
        .nc_addr              (nc_addr),
        .nc_data              (nc_data),
        .nc_wren              (nc_wren),
        .gl_addr              (gl_addr),
        .gl_data              (gl_data),
        .gl_wren              (gl_wren),
        .gl_busy              (gl_busy),
        .new_game_in_progress (new_game_in_progress),
        .gl_hold              (gl_hold),
        .game_active          (game_active),
        .load_error           (load_error),
        .om_addr              (om_addr),
        .om_data              (om_data),
        .om_wren              (om_wren)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock: predict from the inputs present at the edge, then
    // compare every output 1 time unit after the edge.
    task automatic step();
        bit          n_loaded  = m_loaded;
        bit          n_waiting = m_waiting;
        bit          n_granted = m_granted;
        bit          n_err     = m_err;
        int          n_age     = m_age;
        logic [6:0]  n_addr    = '0;
        logic [10:0] n_data    = '0;
        bit          n_wren    = 0;
        bit          src_wren  = 0;
        if (reset) begin
            n_loaded = 0; n_waiting = 0; n_granted = 0; n_err = 0; n_age = 0;
        end else begin
            if (m_granted) begin
                n_addr = nc_addr; n_data = nc_data; src_wren = nc_wren;
            end else if (m_waiting || m_loaded) begin
                n_addr = gl_addr; n_data = gl_data; src_wren = gl_wren;
            end
            n_wren = src_wren && (int'(n_addr) < 104);
            if (m_granted) begin
                if (new_game_ready) begin
                    n_granted = 0; n_loaded = 1;
                end else if (m_age + 1 >= 255) begin
                    n_granted = 0; n_loaded = 0; n_err = 1;
                end else begin
                    n_age = m_age + 1;
                end
            end else if (m_waiting) begin
                if (!gl_busy) begin
                    n_waiting = 0; n_granted = 1; n_age = 0; n_err = 0;
                end
            end else if (new_game_request) begin
                n_waiting = 1;
            end
        end
        @(posedge clk);
        #1;
        m_loaded = n_loaded; m_waiting = n_waiting; m_granted = n_granted;
        m_err = n_err; m_age = n_age;
        m_addr = n_addr; m_data = n_data; m_wren = n_wren;
        check("in_progress", 32'(new_game_in_progress), 32'(m_granted));
        check("gl_hold",     32'(gl_hold),     32'(m_waiting || m_granted));
        check("game_active", 32'(game_active), 32'(m_loaded && !m_waiting && !m_granted));
        check("load_error",  32'(load_error),  32'(m_err));
        check("om_wren",     32'(om_wren),     32'(m_wren));
        check("om_addr",     32'(om_addr),     32'(m_addr));
        check("om_data",     32'(om_data),     32'(m_data));
    endtask

    task automatic quiet_inputs();
        new_game_request = 0; new_game_ready = 0; resetting = 0;
        nc_wren = 0; gl_wren = 0; gl_busy = 0;
        nc_addr = '0; nc_data = '0; gl_addr = '0; gl_data = '0;
    endtask

    task automatic request_and_grant();
        new_game_request = 1;
        step();
        new_game_request = 0;
        step();
    endtask

    initial begin
        // Reset state
        reset = 1;
        step();
        step();
        check("reset_state_wren", 32'(om_wren), 32'(0));
        reset = 0;
        step();

        // Power-up load: grant two cycles after the request, full board write
        request_and_grant();
        check("powerup_in_progress", 32'(new_game_in_progress), 32'(1));
        resetting = 1;
        for (int a = 0; a < 104; a++) begin
            nc_addr = 7'(a); nc_data = 11'($urandom); nc_wren = 1;
            step();
        end
        check("last_board_addr", 32'(om_addr), 32'(103));
        nc_wren = 0; resetting = 0; new_game_ready = 1;
        step();
        new_game_ready = 0;
        step();
        check("powerup_active", 32'(game_active), 32'(1));

        // Play: game-logic writes
        for (int i = 0; i < 20; i++) begin
            gl_addr = 7'($urandom); gl_data = 11'($urandom); gl_wren = 1'($urandom);
            step();
        end

        // Drain: busy for 5 cycles, game writes still pass
        gl_busy = 1; new_game_request = 1;
        gl_addr = 7'd9; gl_data = 11'h2aa; gl_wren = 1;
        step();
        new_game_request = 0;
        check("drain_hold", 32'(gl_hold), 32'(1));
        for (int i = 0; i < 4; i++) begin
            gl_addr = 7'(10 + i); gl_data = 11'($urandom);
            step();
            check("drain_no_grant", 32'(new_game_in_progress), 32'(0));
            check("drain_gl_write", 32'(om_wren), 32'(1));
        end
        gl_busy = 0; gl_wren = 0;
        step();
        check("drain_grant", 32'(new_game_in_progress), 32'(1));

        // Contention in GRANT: coordinator wins
        gl_wren = 1; gl_addr = 7'd5; nc_wren = 1; nc_addr = 7'd7; nc_data = 11'h123;
        step();
        check("grant_contend_addr", 32'(om_addr), 32'(7));
        check("grant_contend_wren", 32'(om_wren), 32'(1));
        gl_wren = 0;

        // Range gate
        nc_addr = 7'd104;
        step();
        check("range_104", 32'(om_wren), 32'(0));
        nc_addr = 7'd127;
        step();
        check("range_127", 32'(om_wren), 32'(0));
        nc_addr = 7'd103;
        step();
        check("range_103", 32'(om_wren), 32'(1));
        nc_wren = 0; new_game_ready = 1;
        step();
        new_game_ready = 0;

        // Contention in PLAYING: game logic wins
        gl_wren = 1; gl_addr = 7'd5; gl_data = 11'h055; nc_wren = 1; nc_addr = 7'd7;
        step();
        check("play_contend_addr", 32'(om_addr), 32'(5));
        quiet_inputs();
        step();

        // Random phase
        for (int i = 0; i < 400; i++) begin
            new_game_request = ($urandom_range(15) == 0);
            new_game_ready   = ($urandom_range(15) == 0);
            gl_busy  = ($urandom_range(2) == 0);
            gl_addr  = 7'($urandom); gl_data = 11'($urandom); gl_wren = 1'($urandom);
            nc_addr  = 7'($urandom); nc_data = 11'($urandom); nc_wren = 1'($urandom);
            step();
        end
        quiet_inputs();
        step();
        step();

        // Ready on the last allowed GRANT cycle wins over the watchdog
        request_and_grant();
        if (!m_granted) request_and_grant();
        for (int i = 0; i < 254; i++) step();
        new_game_ready = 1;
        step();
        new_game_ready = 0;
        check("ready_at_timeout_active", 32'(game_active), 32'(1));
        check("ready_at_timeout_err", 32'(load_error), 32'(0));

        // Watchdog abort
        request_and_grant();
        for (int i = 0; i < 260; i++) step();
        check("watchdog_err", 32'(load_error), 32'(1));
        check("watchdog_idle", 32'(new_game_in_progress), 32'(0));
        request_and_grant();
        check("err_cleared_on_grant", 32'(load_error), 32'(0));

        // Reset mid-GRANT, then a late ready is ignored
        for (int a = 0; a <= 50; a++) begin
            nc_addr = 7'(a); nc_data = 11'($urandom); nc_wren = 1;
            if (a == 50) reset = 1;
            step();
        end
        check("midreset_wren", 32'(om_wren), 32'(0));
        check("midreset_in_progress", 32'(new_game_in_progress), 32'(0));
        reset = 0; nc_wren = 0; new_game_ready = 1;
        step();
        new_game_ready = 0;
        step();
        check("late_ready_ignored", 32'(game_active), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
